// File: rtl/wb_bus_interface_gen_if.sv
// Wishbone slave-side bus bundle between the system bus and the USB core front end.
interface wb_bus_interface_gen_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              cyc_i;
  logic              stb_i;
  logic              we_i;
  logic [ADDR_W-1:0] adr_i;
  logic [DATA_W-1:0] dat_i;
  logic [DATA_W-1:0] dat_o;
  logic              ack_o;
  logic              err_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_bus_interface_gen.sv
// Wishbone slave front end: region decode, wait-stated FIFO reads, one strobe per transfer.
// Latency: ack/err one cycle after accept (READ_WAIT more on FIFO-head reads); no backpressure beyond ack.
module wb_bus_interface_gen #(
  parameter int                     DATA_W       = 8,
  parameter int                     ADDR_W       = 8,
  parameter int                     REGION_SHIFT = 4,
  parameter int                     NUM_REGIONS  = 15,
  parameter logic [NUM_REGIONS-1:0] WAIT_MASK    = 15'h3FFC,
  parameter int                     READ_WAIT    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  wb_bus_interface_gen_if.slave         wb,
  input  logic [NUM_REGIONS*DATA_W-1:0] rdata_i,
  output logic [NUM_REGIONS-1:0]        sel_o,
  output logic [REGION_SHIFT-1:0]       adr_o,
  output logic [DATA_W-1:0]             wr_dat_o,
  output logic                          rd_strb_o,
  output logic                          wr_strb_o
);
  localparam int RW = ADDR_W - REGION_SHIFT;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [RW-1:0]     reg_q;
  logic [RW-1:0]     in_region;
  logic [RW-1:0]     rd_region;
  logic              in_mapped;
  logic              wait_hit;
  logic [NUM_REGIONS-1:0] onehot;
  logic [DATA_W-1:0] rd_slice;

  assign in_region = wb.adr_i[ADDR_W-1:REGION_SHIFT];
  // A waited read samples the region latched at accept, not the live address.
  assign rd_region = (state == IDLE) ? in_region : reg_q;

  always_comb begin
    in_mapped = 1'b0;
    wait_hit  = 1'b0;
    onehot    = '0;
    rd_slice  = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (in_region == RW'(i)) begin
        in_mapped = 1'b1;
        onehot[i] = 1'b1;
        wait_hit  = WAIT_MASK[i];
      end
      if (rd_region == RW'(i))
        rd_slice = rdata_i[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      reg_q     <= '0;
      sel_o     <= '0;
      adr_o     <= '0;
      wr_dat_o  <= '0;
      rd_strb_o <= 1'b0;
      wr_strb_o <= 1'b0;
      wb.dat_o  <= '0;
      wb.ack_o  <= 1'b0;
      wb.err_o  <= 1'b0;
    end else begin
      wb.ack_o  <= 1'b0;
      wb.err_o  <= 1'b0;
      rd_strb_o <= 1'b0;
      wr_strb_o <= 1'b0;
      case (state)
        IDLE: if (wb.cyc_i && wb.stb_i) begin
          reg_q    <= in_region;
          adr_o    <= wb.adr_i[REGION_SHIFT-1:0];
          wr_dat_o <= wb.dat_i;
          if (!in_mapped) begin
            state    <= ERR;
            wb.err_o <= 1'b1;
          end else begin
            sel_o <= onehot;
            if (!wb.we_i && wait_hit && wb.adr_i[REGION_SHIFT-1:0] == '0) begin
              state <= WAIT;
              cnt   <= 3'(READ_WAIT - 1);
            end else begin
              state    <= ACK;
              wb.ack_o <= 1'b1;
              if (wb.we_i) begin
                wr_strb_o <= 1'b1;
              end else begin
                rd_strb_o <= 1'b1;
                wb.dat_o  <= rd_slice;
              end
            end
          end
        end
        WAIT: begin
          if (!wb.cyc_i) begin
            state <= IDLE;
            sel_o <= '0;
          end else if (cnt == 3'd0) begin
            state     <= ACK;
            wb.ack_o  <= 1'b1;
            rd_strb_o <= 1'b1;
            wb.dat_o  <= rd_slice;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ACK: begin
          state <= IDLE;
          sel_o <= '0;
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_bus_interface_gen.sv
// Bench for wb_bus_interface_gen: two instances (READ_WAIT=1 and 3) sharing one stimulus bus.
module tb_wb_bus_interface_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bit          which;
  logic        cyc, stb, we;
  logic [7:0]  adr, dat;
  logic [7:0]  rmem [15];
  logic [119:0] rdata;

  logic [14:0] sel1, sel3;
  logic [3:0]  adro1, adro3;
  logic [7:0]  wrd1, wrd3;
  logic        rds1, rds3, wrs1, wrs3;

  wb_bus_interface_gen_if #(.DATA_W(8), .ADDR_W(8)) b1 ();
  wb_bus_interface_gen_if #(.DATA_W(8), .ADDR_W(8)) b3 ();

  assign b1.cyc_i = cyc & ~which;
  assign b1.stb_i = stb & ~which;
  assign b3.cyc_i = cyc & which;
  assign b3.stb_i = stb & which;
  assign b1.we_i = we;   assign b3.we_i = we;
  assign b1.adr_i = adr; assign b3.adr_i = adr;
  assign b1.dat_i = dat; assign b3.dat_i = dat;

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 15; i++) rdata[i*8 +: 8] = rmem[i];
  end

  wb_bus_interface_gen #(.READ_WAIT(1)) dut1 (
    .clk(clk), .rst(rst), .wb(b1), .rdata_i(rdata), .sel_o(sel1), .adr_o(adro1),
    .wr_dat_o(wrd1), .rd_strb_o(rds1), .wr_strb_o(wrs1));
  wb_bus_interface_gen #(.READ_WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .wb(b3), .rdata_i(rdata), .sel_o(sel3), .adr_o(adro3),
    .wr_dat_o(wrd3), .rd_strb_o(rds3), .wr_strb_o(wrs3));

  logic        o_ack, o_err, o_rd, o_wr;
  logic [14:0] o_sel;
  logic [3:0]  o_adr;
  logic [7:0]  o_dat, o_wrd;
  always_comb begin
    o_ack = which ? b3.ack_o : b1.ack_o;
    o_err = which ? b3.err_o : b1.err_o;
    o_rd  = which ? rds3 : rds1;
    o_wr  = which ? wrs3 : wrs1;
    o_sel = which ? sel3 : sel1;
    o_adr = which ? adro3 : adro1;
    o_dat = which ? b3.dat_o : b1.dat_o;
    o_wrd = which ? wrd3 : wrd1;
  end

  int checks = 0;
  int failures = 0;
  logic [7:0]  last_dat [2];
  logic [14:0] wmask = 15'h3FFC;
  int          rwait [2] = '{1, 3};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete transfer, held until ack/err, with outputs checked in the response cycle.
  task automatic run_xfer(input bit w, input bit iwe, input logic [7:0] iadr, input logic [7:0] idat,
                          input logic [7:0] ird, input int elat, input bit eerr,
                          input logic [14:0] esel, input logic [7:0] edat);
    int n = 0;
    int bad = 0;
    bit done = 0;
    @(negedge clk);
    which = w;
    if (!iwe && iadr[7:4] != 4'hF) rmem[iadr[7:4]] = ird;
    cyc = 1'b1; stb = 1'b1; we = iwe; adr = iadr; dat = idat;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (o_ack || o_err) done = 1;
      else if (o_rd || o_wr || (n > 1 && o_sel !== esel)) bad++;
    end
    check("latency", n, elat);
    check("wait_cycles_clean", bad, 0);
    check("ack", o_ack, !eerr);
    check("err", o_err, eerr);
    check("sel", o_sel, esel);
    check("rd_strb", o_rd, !eerr && !iwe);
    check("wr_strb", o_wr, !eerr && iwe);
    check("dat_o", o_dat, edat);
    if (!eerr) begin
      check("adr_o", o_adr, iadr[3:0]);
      check("wr_dat_o", o_wrd, idat);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("single_pulse", {o_ack, o_err, o_rd, o_wr}, 4'b0);
    check("sel_clear", o_sel, 15'h0);
    last_dat[w] = edat;
  endtask

  typedef struct {
    bit          w;
    bit          we;
    logic [7:0]  adr;
    logic [7:0]  dat;
    logic [7:0]  rd;
    int          lat;
    bit          err;
    logic [14:0] sel;
    logic [7:0]  edat;
  } vec_t;

  vec_t vt [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acks, strbs, quiet;
    for (int i = 0; i < 15; i++) rmem[i] = 8'h00;
    last_dat[0] = 8'h00; last_dat[1] = 8'h00;

    vt[0] = '{0, 1, 8'h45, 8'hA5, 8'h00, 1, 0, 15'h0010, 8'h00};
    vt[1] = '{0, 0, 8'h20, 8'h00, 8'h3C, 2, 0, 15'h0004, 8'h3C};
    vt[2] = '{1, 0, 8'h20, 8'h00, 8'h3C, 4, 0, 15'h0004, 8'h3C};
    vt[3] = '{0, 0, 8'h21, 8'h00, 8'h5A, 1, 0, 15'h0004, 8'h5A};
    vt[4] = '{0, 0, 8'hF0, 8'h00, 8'h00, 1, 1, 15'h0000, 8'h5A};
    vt[5] = '{0, 1, 8'h00, 8'h11, 8'h00, 1, 0, 15'h0001, 8'h5A};
    vt[6] = '{0, 0, 8'h10, 8'h00, 8'h77, 1, 0, 15'h0002, 8'h77};
    vt[7] = '{0, 0, 8'hE0, 8'h00, 8'h99, 1, 0, 15'h4000, 8'h99};
    vt[8] = '{1, 0, 8'hD0, 8'h00, 8'hC3, 4, 0, 15'h2000, 8'hC3};
    vt[9] = '{1, 1, 8'h30, 8'h42, 8'h00, 1, 0, 15'h0008, 8'hC3};

    // Reset held with a live strobe: every output stays low.
    which = 0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h45; dat = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut1", {b1.ack_o, b1.err_o, rds1, wrs1, sel1, adro1, b1.dat_o, wrd1}, 64'h0);
    check("reset_dut3", {b3.ack_o, b3.err_o, rds3, wrs3, sel3, adro3, b3.dat_o, wrd3}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ack", {o_ack, o_rd, o_sel}, {1'b1, 1'b1, 15'h0010});
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", {o_ack, o_sel}, 16'h0);

    for (int i = 0; i < 10; i++)
      run_xfer(vt[i].w, vt[i].we, vt[i].adr, vt[i].dat, vt[i].rd,
               vt[i].lat, vt[i].err, vt[i].sel, vt[i].edat);

    // stb held high across four no-wait reads.
    rmem[2] = 8'h5A;
    acks = 0; strbs = 0;
    @(negedge clk);
    which = 0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h21;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      acks += int'(o_ack);
      strbs += int'(o_rd);
      check("b2b_ack_pattern", o_ack, i % 2);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    check("b2b_acks", acks, 4);
    check("b2b_rd_strbs", strbs, 4);
    check("b2b_dat_o", o_dat, 8'h5A);
    last_dat[0] = 8'h5A;

    // Abort during a wait-stated read on the READ_WAIT=3 instance.
    @(negedge clk);
    which = 1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h20;
    @(posedge clk); #1;
    check("abort_wait_sel", {o_ack, o_sel}, {1'b0, 15'h0004});
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("abort_sel_clear", o_sel, 15'h0);
    quiet = 0;
    repeat (5) begin
      if (o_ack || o_err || o_rd || o_wr) quiet++;
      @(posedge clk); #1;
    end
    check("abort_no_ack", quiet, 0);
    run_xfer(1, 0, 8'h21, 8'h00, 8'h6E, 1, 0, 15'h0004, 8'h6E);

    // Random transfers against the abstract timing/decode rules.
    for (int t = 0; t < 40; t++) begin
      bit          rw_w, rw_we, e_err;
      logic [7:0]  r_adr, r_dat, r_rd, e_dat;
      logic [3:0]  reg_i;
      logic [14:0] e_sel;
      int          e_lat;
      rw_w  = 1'($urandom_range(0, 1));
      rw_we = 1'($urandom_range(0, 1));
      r_adr = 8'($urandom);
      if (t % 3 == 0) r_adr[3:0] = 4'h0;
      r_dat = 8'($urandom);
      r_rd  = 8'($urandom);
      reg_i = r_adr[7:4];
      e_err = (reg_i >= 4'd15);
      e_lat = 1;
      e_sel = 15'h0;
      e_dat = last_dat[rw_w];
      if (!e_err) begin
        e_sel = 15'h1 << reg_i;
        if (!rw_we) begin
          e_dat = r_rd;
          if (wmask[reg_i] && r_adr[3:0] == 4'h0) e_lat = 1 + rwait[rw_w];
        end
      end
      run_xfer(rw_w, rw_we, r_adr, r_dat, r_rd, e_lat, e_err, e_sel, e_dat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
